jmul8_seq_ctrl: RTL and testbench

//  Sequencer that time-shares one external 4x4 unsigned array multiplier to

---
 rtl/jmul8_seq_ctrl.sv | 118 +++++++++++
 tb/tb_jmul8_seq_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/jmul8_seq_ctrl.sv
// Sequencer that time-shares one external 4x4 multiplier to form 8x8 unsigned products.
// Optional feature: define JMUL_SEQ_ZERO_BYPASS_EN to skip the MUL steps when an operand is zero.
module jmul8_seq_ctrl #(
  parameter int W_SUB = 4,
  parameter int W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_a,
  input  logic [W-1:0]       in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*W-1:0]     out_p,
  output logic [W_SUB-1:0]   mul_a,
  output logic [W_SUB-1:0]   mul_b,
  input  logic [2*W_SUB-1:0] mul_p,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state, state_nx;
  logic [1:0]     step, step_nx;
  logic [2*W-1:0] acc, acc_nx;
  logic [W-1:0]   op_a, op_a_nx;
  logic [W-1:0]   op_b, op_b_nx;
  logic [2*W-1:0] part;
  logic           zero_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      step  <= 2'd0;
      acc   <= '0;
      op_a  <= '0;
      op_b  <= '0;
    end else begin
      state <= state_nx;
      step  <= step_nx;
      acc   <= acc_nx;
      op_a  <= op_a_nx;
      op_b  <= op_b_nx;
    end
  end

  // step[0] picks the high nibble of A, step[1] the high nibble of B;
  // the partial-product weight is the sum of the two nibble weights.
  always_comb begin
    part = (2*W)'(mul_p);
    case (step)
      2'd0:    part = (2*W)'(mul_p);
      2'd3:    part = (2*W)'(mul_p) << (2*W_SUB);
      default: part = (2*W)'(mul_p) << W_SUB;
    endcase
  end

`ifdef JMUL_SEQ_ZERO_BYPASS_EN
  assign zero_op = (in_a == '0) || (in_b == '0);
`else
  assign zero_op = 1'b0;
`endif

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // in_ready is high only in IDLE, out_valid only in DONE and held until out_ready.
  always_comb begin
    state_nx  = state;
    step_nx   = step;
    acc_nx    = acc;
    op_a_nx   = op_a;
    op_b_nx   = op_b;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    mul_a     = '0;
    mul_b     = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          op_a_nx  = in_a;
          op_b_nx  = in_b;
          acc_nx   = '0;
          step_nx  = 2'd0;
          state_nx = zero_op ? DONE : MUL;
        end
      end
      MUL: begin
        busy   = 1'b1;
        mul_a  = step[0] ? op_a[W-1:W_SUB] : op_a[W_SUB-1:0];
        mul_b  = step[1] ? op_b[W-1:W_SUB] : op_b[W_SUB-1:0];
        acc_nx = acc + part;
        if (step == 2'd3) begin
          step_nx  = 2'd0;
          state_nx = DONE;
        end else begin
          step_nx = step + 2'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
        step_nx  = 2'd0;
      end
    endcase
  end

  assign out_p = acc;

endmodule

// File: tb/tb_jmul8_seq_ctrl.sv
// Directed bench for jmul8_seq_ctrl with a behavioural 4x4 multiplier and a product scoreboard.
module tb_jmul8_seq_ctrl;

`ifdef JMUL_SEQ_ZERO_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_p;
  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [7:0]  mul_p;
  logic        busy;

  int tests_run;
  int tests_failed;
  logic [15:0] exp_q[$];

  jmul8_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .busy      (busy)
  );

  // Shared combinational 4x4 multiplier seen by the sequencer.
  assign mul_p = {4'h0, mul_a} * {4'h0, mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    assert (obs === exp_v) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_p"}, 32'(out_p), 32'd0);
    chk({tag, "_mul_a"}, 32'(mul_a), 32'd0);
    chk({tag, "_mul_b"}, 32'(mul_b), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Called just after a negedge; returns just after a negedge with the DUT back in IDLE.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int hold,
                        input bit inject, input bit chk_seq);
    int         lat;
    int         n_busy;
    int         exp_lat;
    logic [7:0] pairs[4];
    logic [15:0] e;
    logic [15:0] front;
    exp_lat = (BYPASS && (a == 8'h00 || b == 8'h00)) ? 1 : 5;
    for (int i = 0; i < 4; i++) pairs[i] = 8'h00;
    in_a      = a;
    in_b      = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    chk("accept_in_ready", 32'(in_ready), 32'd1);
    e = 16'(a) * 16'(b);
    exp_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (inject) begin
      in_a = 8'h05;
      in_b = 8'h05;
    end else begin
      in_valid = 1'b0;
    end
    lat    = 1;
    n_busy = 0;
    while (!out_valid && lat < 20) begin
      if (lat <= 4) pairs[lat-1] = {mul_a, mul_b};
      if (busy) n_busy++;
      if (inject) chk("inject_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("busy_cycles", 32'(n_busy), (exp_lat == 5) ? 32'd4 : 32'd0);
    if (chk_seq) begin
      chk("seq_step0", 32'(pairs[0]), 32'h24);
      chk("seq_step1", 32'(pairs[1]), 32'h14);
      chk("seq_step2", 32'(pairs[2]), 32'h23);
      chk("seq_step3", 32'(pairs[3]), 32'h13);
    end
    front = (exp_q.size() != 0) ? exp_q[0] : 16'hxxxx;
    for (int i = 0; i < hold; i++) begin
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_out_p", 32'(out_p), 32'(front));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    chk("done_out_valid", 32'(out_valid), 32'd1);
    chk("done_mul_idle", 32'({mul_a, mul_b}), 32'd0);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("product", 32'(out_p), 32'(e));
    end else begin
      chk("scoreboard_empty", 32'd0, 32'd1);
    end
    @(negedge clk);
    out_ready = 1'b0;
    chk("after_out_valid", 32'(out_valid), 32'd0);
    chk("after_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = 8'h00;
    in_b      = 8'h00;
    out_ready = 1'b0;

    // Reset and idle
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset_outputs("idle");

    // Max operands, out_ready already high
    run_op(8'hFF, 8'hFF, 0, 1'b0, 1'b0);
    // Nibble sequence check
    run_op(8'h12, 8'h34, 0, 1'b0, 1'b1);
    // Backpressure for 3 cycles with ignored in_valid during MUL
    run_op(8'h12, 8'h34, 3, 1'b1, 1'b0);
    run_op(8'hA5, 8'h3C, 1, 1'b0, 1'b0);

    // Reset in the middle of step 2
    in_a     = 8'h12;
    in_b     = 8'h34;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("midrst_step2_mul", 32'({mul_a, mul_b}), 32'h23);
    chk("midrst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_out_valid", 32'(out_valid), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_no_out_valid_after", 32'(out_valid), 32'd0);
    run_op(8'h03, 8'h07, 0, 1'b0, 1'b0);

    // Zero operands
    run_op(8'h00, 8'hAB, 0, 1'b0, 1'b0);
    run_op(8'hCD, 8'h00, 2, 1'b0, 1'b0);

    // Random operands
    for (int i = 0; i < 6; i++) begin
      run_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             int'($urandom_range(0, 2)), 1'b0, 1'b0);
    end

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
